// File: rtl/note_distributor.sv
// Polyphonic voice allocator and sawtooth mixer: latches incoming notes into free voices,
// counts their durations down on beats and sums active voices into a 16-bit sample.
module note_distributor #(
   parameter int NUM_VOICES = 3,
   parameter int PHASE_W    = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        play,
   input  logic        beat,
   input  logic        load_new_note,
   input  logic [5:0]  note_to_load,
   input  logic [5:0]  duration_to_load,
   input  logic        generate_next_sample,
   input  logic        new_frame,
   output logic [15:0] sample_out,
   output logic        new_sample_ready
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic               active_q    [NUM_VOICES];
   logic               active_d    [NUM_VOICES];
   logic [5:0]         note_q      [NUM_VOICES];
   logic [5:0]         note_d      [NUM_VOICES];
   logic [5:0]         remaining_q [NUM_VOICES];
   logic [5:0]         remaining_d [NUM_VOICES];
   logic [PHASE_W-1:0] phase_q     [NUM_VOICES];
   logic [PHASE_W-1:0] phase_d     [NUM_VOICES];
   logic [15:0]        sample_q;
   logic [15:0]        sample_d;
   logic               sampleReady_q;
   logic               sampleReady_d;

   logic               loadOk;
   logic               freeFound;
   logic [IDX_W-1:0]   freeIdx;
   logic signed [15:0] wave;
   logic signed [15:0] mixSum;
   logic               unused_frame;

   assign unused_frame = new_frame;

   // Phase increment per sample: semitone base for 48 kHz, doubled once per octave above A1.
   function automatic logic [PHASE_W-1:0] noteStep(input logic [5:0] note);
      logic [5:0]  idx;
      logic [5:0]  semi;
      logic [5:0]  oct;
      logic [11:0] base;
      idx  = note - 6'd1;
      semi = idx % 6'd12;
      oct  = idx / 6'd12;
      case (semi)
         6'd0:    base = 12'd1201;
         6'd1:    base = 12'd1273;
         6'd2:    base = 12'd1348;
         6'd3:    base = 12'd1428;
         6'd4:    base = 12'd1513;
         6'd5:    base = 12'd1603;
         6'd6:    base = 12'd1698;
         6'd7:    base = 12'd1799;
         6'd8:    base = 12'd1906;
         6'd9:    base = 12'd2020;
         6'd10:   base = 12'd2140;
         default: base = 12'd2267;
      endcase
      return PHASE_W'(base) << oct;
   endfunction

   always_comb begin
      loadOk    = load_new_note && play && (note_to_load != 6'd0) && (duration_to_load != 6'd0);
      freeFound = 1'b0;
      freeIdx   = '0;
      sample_d  = sample_q;
      mixSum    = '0;
      wave      = '0;
      sampleReady_d = generate_next_sample;

      // Walk downward so the lowest-index idle voice wins; uses pre-edge activity only.
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!active_q[v]) begin
            freeFound = 1'b1;
            freeIdx   = IDX_W'(v);
         end
      end

      for (int v = 0; v < NUM_VOICES; v++) begin
         active_d[v]    = active_q[v];
         note_d[v]      = note_q[v];
         remaining_d[v] = remaining_q[v];
         phase_d[v]     = phase_q[v];
         if (play && beat && active_q[v]) begin
            remaining_d[v] = remaining_q[v] - 6'd1;
            if (remaining_q[v] == 6'd1) begin
               active_d[v] = 1'b0;
            end
         end
         if (play && generate_next_sample && active_q[v]) begin
            phase_d[v] = phase_q[v] + noteStep(note_q[v]);
         end
      end

      if (loadOk && freeFound) begin
         active_d[freeIdx]    = 1'b1;
         note_d[freeIdx]      = note_to_load;
         remaining_d[freeIdx] = duration_to_load;
         phase_d[freeIdx]     = '0;
      end

      // Sawtooth from the top phase bits, attenuated by 4 so several voices cannot overflow.
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (active_d[v]) begin
            wave   = $signed({~phase_d[v][PHASE_W-1], phase_d[v][PHASE_W-2 -: 15]});
            mixSum = mixSum + (wave >>> 2);
         end
      end

      if (generate_next_sample) begin
         sample_d = play ? mixSum : 16'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            active_q[v]    <= 1'b0;
            note_q[v]      <= '0;
            remaining_q[v] <= '0;
            phase_q[v]     <= '0;
         end
         sample_q      <= '0;
         sampleReady_q <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            active_q[v]    <= active_d[v];
            note_q[v]      <= note_d[v];
            remaining_q[v] <= remaining_d[v];
            phase_q[v]     <= phase_d[v];
         end
         sample_q      <= sample_d;
         sampleReady_q <= sampleReady_d;
      end
   end

   assign sample_out       = sample_q;
   assign new_sample_ready = sampleReady_q;

endmodule

// File: tb/tb_note_distributor.sv
// Directed bench for note_distributor: hand-computed mixed samples across allocation,
// beat expiry, pause/resume, ignored loads and asynchronous reset.
module tb_note_distributor;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic        beat;
   logic        load_new_note;
   logic [5:0]  note_to_load;
   logic [5:0]  duration_to_load;
   logic        generate_next_sample;
   logic        new_frame;
   logic [15:0] sample_out;
   logic        new_sample_ready;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   note_distributor dut (
      .clk                  (clk),
      .reset                (reset),
      .play                 (play),
      .beat                 (beat),
      .load_new_note        (load_new_note),
      .note_to_load         (note_to_load),
      .duration_to_load     (duration_to_load),
      .generate_next_sample (generate_next_sample),
      .new_frame            (new_frame),
      .sample_out           (sample_out),
      .new_sample_ready     (new_sample_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of pulses, then drops them; outputs afterwards reflect that edge.
   task automatic applyStimulus(input logic b, input logic ld, input logic [5:0] n,
                                input logic [5:0] d, input logic g);
      beat                 = b;
      load_new_note        = ld;
      note_to_load         = n;
      duration_to_load     = d;
      generate_next_sample = g;
      step();
      beat                 = 1'b0;
      load_new_note        = 1'b0;
      note_to_load         = 6'd0;
      duration_to_load     = 6'd0;
      generate_next_sample = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int expSample, input logic expReady);
      logic [15:0] expBits;
      expBits = 16'(expSample);
      compared++;
      assert (sample_out === expBits)
      else begin
         mismatched++;
         $error("[TB] FAIL %s sample_out: observed %0d (%h) expected %0d (%h)",
                tag, $signed(sample_out), sample_out, expSample, expBits);
      end
      compared++;
      assert (new_sample_ready === expReady)
      else begin
         mismatched++;
         $error("[TB] FAIL %s new_sample_ready: observed %b expected %b",
                tag, new_sample_ready, expReady);
      end
   endtask

   initial begin
      reset                = 1'b1;
      play                 = 1'b0;
      beat                 = 1'b0;
      load_new_note        = 1'b0;
      note_to_load         = 6'd0;
      duration_to_load     = 6'd0;
      generate_next_sample = 1'b0;
      new_frame            = 1'b0;

      #15;
      checkOutput("reset", 0, 1'b0);
      #5;
      reset = 1'b0;
      step();

      // With nothing loaded every voice is idle, so a request yields silence.
      play = 1'b1;
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("idleMix", 0, 1'b1);

      // Note 40 steps 11424 per sample.
      applyStimulus(1'b0, 1'b1, 6'd40, 6'd3, 1'b0);
      checkOutput("afterLoad", 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("firstSample", -8014, 1'b1);
      step();
      checkOutput("holdSample", -8014, 1'b0);

      // Fill the remaining voices; the fourth note has nowhere to go.
      applyStimulus(1'b0, 1'b1, 6'd44, 6'd3, 1'b0);
      applyStimulus(1'b0, 1'b1, 6'd47, 6'd3, 1'b0);
      new_frame = 1'b1;
      applyStimulus(1'b0, 1'b1, 6'd50, 6'd3, 1'b0);
      new_frame = 1'b0;
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("threeVoices", -23728, 1'b1);

      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("afterTwoBeats", -23057, 1'b1);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("allExpired", 0, 1'b1);

      // Voice 0 is free again and starts from phase 0.
      applyStimulus(1'b0, 1'b1, 6'd50, 6'd3, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("reloadVoice0", -7874, 1'b1);

      // Paused: beats, loads and phase advance are all ignored.
      play = 1'b0;
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 6'd40, 6'd3, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("pausedSilent", 0, 1'b1);
      play = 1'b1;
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("resumePhase", -7556, 1'b1);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("resumeDuration", -7238, 1'b1);
      applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("resumeExpire", 0, 1'b1);

      // Rests and zero durations never claim a voice.
      applyStimulus(1'b0, 1'b1, 6'd0, 6'd5, 1'b0);
      applyStimulus(1'b0, 1'b1, 6'd12, 6'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("ignoredLoads", 0, 1'b1);

      applyStimulus(1'b0, 1'b1, 6'd40, 6'd3, 1'b0);
      generate_next_sample = 1'b1;
      step();
      checkOutput("backToBack1", -8014, 1'b1);
      step();
      checkOutput("backToBack2", -7835, 1'b1);
      generate_next_sample = 1'b0;
      step();
      checkOutput("backToBackHold", -7835, 1'b0);

      // Asynchronous reset between edges clears outputs at once.
      #3;
      reset = 1'b1;
      #1;
      checkOutput("asyncReset", 0, 1'b0);
      #2;
      reset = 1'b0;
      step();
      applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      checkOutput("clearedVoices", 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
